// File: rtl/avalon_bus_arbiter_pkg.sv
// Shared types and constants for the Avalon bus arbiter.
// Holds the FSM state enum, the owner encodings and the default widths.
package mips_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

endpackage

// File: rtl/avalon_bus_arbiter_if.sv
// Avalon-MM master port bundle between the arbiter and the bus pins.
// The master modport drives the command; the slave modport returns data and stall.
interface avalon_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                waitrequest;

    modport master (
        output address, read, write, byteenable, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/avalon_bus_arbiter_arb_pick.sv
// Combinational winner select between fetch and load/store.
// ARB_ROUND_ROBIN_EN: on a tie the requester other than owner wins; else load/store wins.
module arb_pick
    import mips_bus_pkg::*;
(
    input  logic if_req,
    input  logic ls_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic owner,
`endif
    output logic gnt_vld,
    output logic gnt_ls
);

    // Pick a winner; a lone request always wins.
    always_comb begin
        gnt_vld = if_req | ls_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (if_req && ls_req) begin
            gnt_ls = (owner == OWNER_IF);
        end else begin
            gnt_ls = ls_req;
        end
`else
        gnt_ls = ls_req;
`endif
    end

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Shares one Avalon-MM master between instruction fetch and load/store.
// ARB_ROUND_ROBIN_EN selects alternating grants on ties (default: load/store first).
module avalon_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W = mips_bus_pkg::ADDR_W,
    parameter int DATA_W = mips_bus_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_byteen,
    output logic                ls_ack,
    output logic [DATA_W-1:0]   ls_rdata,

    avalon_bus_arbiter_if.master bus,

    output logic                owner
);

    arb_state_t          state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] be_q;
    logic                read_q;
    logic                write_q;
    logic                if_ack_q;
    logic                ls_ack_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   ls_rdata_q;
    logic                owner_q;

    logic                gnt_vld;
    logic                gnt_ls;

    arb_pick u_pick (
        .if_req  (if_req),
        .ls_req  (ls_req),
`ifdef ARB_ROUND_ROBIN_EN
        .owner   (owner_q),
`endif
        .gnt_vld (gnt_vld),
        .gnt_ls  (gnt_ls)
    );

    // Access FSM: latch the winner's command, hold it through stalls, then ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            if_ack_q   <= 1'b0;
            ls_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            owner_q    <= OWNER_IF;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        state_q <= BUSY;
                        owner_q <= gnt_ls;
                        if (gnt_ls) begin
                            addr_q  <= ls_addr;
                            wdata_q <= ls_wdata;
                            be_q    <= ls_byteen;
                            read_q  <= ~ls_we;
                            write_q <= ls_we;
                        end else begin
                            addr_q  <= if_addr;
                            be_q    <= '1;
                            read_q  <= 1'b1;
                            write_q <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (!bus.waitrequest) begin
                        state_q <= RESP;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        if (owner_q == OWNER_LS) begin
                            ls_ack_q <= 1'b1;
                            if (read_q) ls_rdata_q <= bus.readdata;
                        end else begin
                            if_ack_q <= 1'b1;
                            if (read_q) if_rdata_q <= bus.readdata;
                        end
                    end
                end
                RESP: begin
                    state_q  <= IDLE;
                    if_ack_q <= 1'b0;
                    ls_ack_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.address    = addr_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.byteenable = be_q;
    assign bus.writedata  = wdata_q;

    assign if_ack   = if_ack_q;
    assign ls_ack   = ls_ack_q;
    assign if_rdata = if_rdata_q;
    assign ls_rdata = ls_rdata_q;
    assign owner    = owner_q;

endmodule
